// File: rtl/usb_setup_parser.sv
`default_nettype none
// ============================================================================
// Module   : usb_setup_parser
// Purpose  : Control-endpoint SETUP transaction parser. Arms on a SETUP token
//            addressed to this device/endpoint, collects the 8-byte DATA0
//            payload plus CRC16, validates length, PID and CRC, and presents
//            the decoded request fields atomically with a one-cycle strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk             in   1   USB clock (60 MHz)
//   nrst            in   1   synchronous active-low reset
//   dev_addr        in   7   current device address
//   token_in        in  24   {CRC5, ENDP, ADDR, PID}
//   token_in_strb   in   1   token_in valid pulse
//   data_in         in   8   received byte (payload and CRC16)
//   data_in_strb    in   1   data_in valid pulse
//   data_in_end     in   1   end-of-packet pulse
//   data_in_fail    in   1   receive error for current packet
//   pid             in   8   data PID, valid with data_in_end
//   setup_valid     out  1   request accepted pulse
//   setup_err       out  1   request rejected pulse
//   err_code        out  2   0=CRC 1=length 2=PID 3=abort/fail/timeout
//   bm_request_type out  8   request byte 0
//   b_request       out  8   request byte 1
//   w_value         out 16   request bytes 3:2
//   w_index         out 16   request bytes 5:4
//   w_length        out 16   request bytes 7:6
//   busy            out  1   parser not idle
// ============================================================================
module usb_setup_parser #(
    parameter logic [3:0] ENDP        = 4'd0,
    parameter int         TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [6:0]  dev_addr,
    input  logic [23:0] token_in,
    input  logic        token_in_strb,
    input  logic [7:0]  data_in,
    input  logic        data_in_strb,
    input  logic        data_in_end,
    input  logic        data_in_fail,
    input  logic [7:0]  pid,
    output logic        setup_valid,
    output logic        setup_err,
    output logic [1:0]  err_code,
    output logic [7:0]  bm_request_type,
    output logic [7:0]  b_request,
    output logic [15:0] w_value,
    output logic [15:0] w_index,
    output logic [15:0] w_length,
    output logic        busy
);

    localparam logic [7:0]  PID_SETUP   = 8'h2D;
    localparam logic [7:0]  PID_DATA0   = 8'hC3;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_RESID   = 16'hB001;
    localparam logic [3:0]  FRAME_LEN   = 4'd10;
    localparam logic [3:0]  COUNT_MAX   = 4'd11;
    localparam logic [9:0]  TIMEOUT_VAL = 10'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        COLLECT   = 2'd2,
        CHECK     = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [3:0]  count, count_n;
    logic [15:0] crc, crc_n;
    logic [9:0]  timer, timer_n;
    logic [7:0]  pid_q, pid_n;
    logic [7:0]  shadow [0:7];
    logic        shadow_we;
    logic        valid_n, err_n, load_fields;
    logic [1:0]  code_n;
    logic        setup_match;

    // Token CRC5 is checked upstream; the field is deliberately not consumed.
    logic unused_crc5;
    assign unused_crc5 = ^token_in[23:19];

    assign setup_match = (token_in[7:0]   == PID_SETUP) &&
                         (token_in[14:8]  == dev_addr)  &&
                         (token_in[18:15] == ENDP);

    // Reflected CRC16 (poly 0xA001), one byte LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_n     = state;
        count_n     = count;
        crc_n       = crc;
        timer_n     = timer;
        pid_n       = pid_q;
        shadow_we   = 1'b0;
        valid_n     = 1'b0;
        err_n       = 1'b0;
        code_n      = err_code;
        load_fields = 1'b0;

        case (state)
            IDLE: begin
                if (token_in_strb && setup_match) begin
                    state_n = WAIT_DATA;
                    count_n = 4'd0;
                    crc_n   = CRC_INIT;
                    timer_n = 10'd0;
                end
            end

            WAIT_DATA, COLLECT: begin
                if (data_in_fail) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    code_n  = 2'd3;
                end else if (token_in_strb) begin
                    if (setup_match) begin
                        // A repeated SETUP restarts collection silently.
                        state_n = WAIT_DATA;
                        count_n = 4'd0;
                        crc_n   = CRC_INIT;
                        timer_n = 10'd0;
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        code_n  = 2'd3;
                    end
                end else begin
                    if (data_in_strb) begin
                        state_n   = COLLECT;
                        shadow_we = (count < 4'd8);
                        crc_n     = crc16_byte(crc, data_in);
                        if (count != COUNT_MAX) begin
                            count_n = count + 4'd1;
                        end
                    end
                    if (data_in_end) begin
                        // Same-cycle byte has already been folded in above.
                        state_n = CHECK;
                        pid_n   = pid;
                    end else if ((state == WAIT_DATA) && !data_in_strb) begin
                        timer_n = timer + 10'd1;
                        if (timer_n == TIMEOUT_VAL) begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                            code_n  = 2'd3;
                        end
                    end
                end
            end

            CHECK: begin
                state_n = IDLE;
                if (data_in_fail) begin
                    err_n  = 1'b1;
                    code_n = 2'd3;
                end else if (count != FRAME_LEN) begin
                    err_n  = 1'b1;
                    code_n = 2'd1;
                end else if (pid_q != PID_DATA0) begin
                    err_n  = 1'b1;
                    code_n = 2'd2;
                end else if (crc != CRC_RESID) begin
                    err_n  = 1'b1;
                    code_n = 2'd0;
                end else begin
                    valid_n     = 1'b1;
                    load_fields = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state           <= IDLE;
            count           <= 4'd0;
            crc             <= CRC_INIT;
            timer           <= 10'd0;
            pid_q           <= 8'h00;
            setup_valid     <= 1'b0;
            setup_err       <= 1'b0;
            err_code        <= 2'd0;
            bm_request_type <= 8'h00;
            b_request       <= 8'h00;
            w_value         <= 16'h0000;
            w_index         <= 16'h0000;
            w_length        <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 8'h00;
            end
        end else begin
            state       <= state_n;
            count       <= count_n;
            crc         <= crc_n;
            timer       <= timer_n;
            pid_q       <= pid_n;
            setup_valid <= valid_n;
            setup_err   <= err_n;
            err_code    <= code_n;
            if (shadow_we) begin
                shadow[count[2:0]] <= data_in;
            end
            if (load_fields) begin
                bm_request_type <= shadow[0];
                b_request       <= shadow[1];
                w_value         <= {shadow[3], shadow[2]};
                w_index         <= {shadow[5], shadow[4]};
                w_length        <= {shadow[7], shadow[6]};
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_setup_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_usb_setup_parser
// Purpose  : Self-checking bench for usb_setup_parser. Stimulus pushes the
//            expected strobe (kind, code, fields, cycle) into a queue; a
//            monitor pops and compares whenever the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_setup_parser;

    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic [23:0] token_in = '0;
    logic        token_in_strb = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_in_strb = 1'b0;
    logic        data_in_end = 1'b0;
    logic        data_in_fail = 1'b0;
    logic [7:0]  pid = '0;
    logic        setup_valid, setup_err, busy;
    logic [1:0]  err_code;
    logic [7:0]  bm_request_type, b_request;
    logic [15:0] w_value, w_index, w_length;

    usb_setup_parser #(.ENDP(4'd0), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .nrst(nrst), .dev_addr(dev_addr),
        .token_in(token_in), .token_in_strb(token_in_strb),
        .data_in(data_in), .data_in_strb(data_in_strb),
        .data_in_end(data_in_end), .data_in_fail(data_in_fail), .pid(pid),
        .setup_valid(setup_valid), .setup_err(setup_err), .err_code(err_code),
        .bm_request_type(bm_request_type), .b_request(b_request),
        .w_value(w_value), .w_index(w_index), .w_length(w_length),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [7:0]  bmrt;
        logic [7:0]  breq;
        logic [15:0] wv;
        logic [15:0] wi;
        logic [15:0] wl;
        int          at;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  frame[$];
    // Reference view of the request-field outputs.
    logic [7:0]  m_bmrt = '0, m_breq = '0;
    logic [15:0] m_wv = '0, m_wi = '0, m_wl = '0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (nrst && (setup_valid || setup_err)) begin
            check("strobe_exclusive", {63'd0, setup_valid & setup_err}, 64'd0);
            check("strobe_expected", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                check("strobe_kind", {63'd0, setup_err}, {63'd0, mon_e.is_err});
                check("strobe_cycle", 64'(cyc), 64'(mon_e.at));
                if (mon_e.is_err) check("err_code", {62'd0, err_code}, {62'd0, mon_e.code});
                check("fields", {bm_request_type, b_request, w_value, w_index, w_length},
                      {mon_e.bmrt, mon_e.breq, mon_e.wv, mon_e.wi, mon_e.wl});
                check("busy_after_strobe", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [1:0] code, input int at);
        exp_t e;
        e.is_err = is_err; e.code = code; e.at = at;
        e.bmrt = m_bmrt; e.breq = m_breq; e.wv = m_wv; e.wi = m_wi; e.wl = m_wl;
        q.push_back(e);
    endtask

    task automatic send_token(input logic [7:0] p, input logic [6:0] a, input logic [3:0] ep);
        token_in      = {5'($urandom_range(0, 31)), ep, a, p};
        token_in_strb = 1'b1;
        tick();
        token_in_strb = 1'b0;
    endtask

    // USB CRC16 of the first n frame bytes, bit-serial, final complement.
    function automatic logic [15:0] usb_crc16(input int n);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frame[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return ~c;
    endfunction

    task automatic build_valid_frame();
        logic [15:0] c;
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back(8'($urandom_range(0, 255)));
        c = usb_crc16(8);
        frame.push_back(c[7:0]);
        frame.push_back(c[15:8]);
    endtask

    // Sends bytes of 'frame' with random gaps; returns edge index of data_in_end.
    task automatic send_frame(input logic [7:0] p, output int end_cyc);
        bit together = bit'($urandom_range(0, 1));
        for (int i = 0; i < frame.size(); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            data_in      = frame[i];
            data_in_strb = 1'b1;
            data_in_end  = together && (i == frame.size() - 1);
            pid          = p;
            tick();
            data_in_strb = 1'b0;
            data_in_end  = 1'b0;
        end
        if (!together) begin
            repeat ($urandom_range(0, 2)) tick();
            data_in_end = 1'b1;
            pid         = p;
            tick();
            data_in_end = 1'b0;
        end
        end_cyc = cyc;
    endtask

    // Reference: decide outcome of a completed frame from the protocol rules.
    task automatic predict(input logic [7:0] p, input int end_cyc);
        if (frame.size() != 10)           push(1'b1, 2'd1, end_cyc + 1);
        else if (p != 8'hC3)              push(1'b1, 2'd2, end_cyc + 1);
        else if ({frame[9], frame[8]} != usb_crc16(8)) push(1'b1, 2'd0, end_cyc + 1);
        else begin
            m_bmrt = frame[0]; m_breq = frame[1];
            m_wv = {frame[3], frame[2]}; m_wi = {frame[5], frame[4]}; m_wl = {frame[7], frame[6]};
            push(1'b0, 2'd0, end_cyc + 1);
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic load_plan_frame();
        logic [7:0] v [10] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        frame.delete();
        for (int i = 0; i < 10; i++) frame.push_back(v[i]);
    endtask

    task automatic armed_frame(input logic [7:0] p);
        int e;
        send_token(8'h2D, dev_addr, 4'd0);
        send_frame(p, e);
        predict(p, e);
        wait_drain(20);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int a;
        repeat (3) tick();
        check("reset_outputs", {setup_valid, setup_err, err_code, bm_request_type, b_request,
                                w_value, w_index, w_length, busy}, 64'd0);
        nrst = 1'b1;
        tick();

        // Known GET_DESCRIPTOR request with explicit expected fields.
        load_plan_frame();
        send_token(8'h2D, 7'd0, 4'd0);
        check("busy_armed", {63'd0, busy}, 64'd1);
        send_frame(8'hC3, e);
        m_bmrt = 8'h80; m_breq = 8'h06; m_wv = 16'h0100; m_wi = 16'h0000; m_wl = 16'h0040;
        push(1'b0, 2'd0, e + 1);
        wait_drain(20);

        // Corrupt CRC byte.
        load_plan_frame(); frame[9] = 8'h95;
        armed_frame(8'hC3);
        // Short and long frames.
        load_plan_frame(); void'(frame.pop_back());
        armed_frame(8'hC3);
        load_plan_frame(); frame.push_back(8'h5A);
        armed_frame(8'hC3);
        // Wrong data PID.
        load_plan_frame();
        armed_frame(8'h4B);

        // Token for another address is ignored, including its data.
        send_token(8'h2D, 7'd5, 4'd0);
        check("busy_foreign_addr", {63'd0, busy}, 64'd0);
        load_plan_frame();
        send_frame(8'hC3, e);
        wait_drain(5);

        // Timeout while waiting for the first data byte.
        send_token(8'h2D, 7'd0, 4'd0);
        push(1'b1, 2'd3, cyc + TMO);
        wait_drain(TMO + 20);
        check("busy_after_timeout", {63'd0, busy}, 64'd0);

        // Long but in-budget wait before data is still accepted.
        send_token(8'h2D, 7'd0, 4'd0);
        repeat (TMO - 40) tick();
        build_valid_frame();
        send_frame(8'hC3, e);
        predict(8'hC3, e);
        wait_drain(20);

        // Receive failure after byte 4.
        send_token(8'h2D, 7'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(i); data_in_strb = 1'b1; tick(); data_in_strb = 1'b0;
        end
        data_in_fail = 1'b1; tick(); data_in_fail = 1'b0;
        push(1'b1, 2'd3, cyc);
        wait_drain(10);

        // Re-armed SETUP after byte 3: only the second frame counts.
        send_token(8'h2D, 7'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            data_in = 8'hEE; data_in_strb = 1'b1; tick(); data_in_strb = 1'b0;
        end
        build_valid_frame();
        armed_frame(8'hC3);

        // Foreign token while collecting aborts.
        send_token(8'h2D, 7'd0, 4'd0);
        data_in = 8'h11; data_in_strb = 1'b1; tick(); data_in_strb = 1'b0;
        send_token(8'h69, 7'd0, 4'd0);
        push(1'b1, 2'd3, cyc);
        wait_drain(10);

        // Reset mid-frame: no strobe, outputs return to zero.
        send_token(8'h2D, 7'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h22; data_in_strb = 1'b1; tick(); data_in_strb = 1'b0;
        end
        nrst = 1'b0;
        tick(); tick();
        check("midframe_reset_outputs", {setup_valid, setup_err, err_code, bm_request_type, b_request,
                                         w_value, w_index, w_length, busy}, 64'd0);
        m_bmrt = '0; m_breq = '0; m_wv = '0; m_wi = '0; m_wl = '0;
        nrst = 1'b1;
        tick();

        // Randomized mix of good and bad transactions.
        for (int it = 0; it < 40; it++) begin
            dev_addr = 7'($urandom_range(0, 127));
            build_valid_frame();
            case ($urandom_range(0, 6))
                0, 1: armed_frame(8'hC3);
                2: begin frame[8 + $urandom_range(0, 1)] ^= 8'(1 << $urandom_range(0, 7)); armed_frame(8'hC3); end
                3: begin
                    if ($urandom_range(0, 1) == 1) begin
                        repeat ($urandom_range(1, 3)) void'(frame.pop_back());
                    end else begin
                        repeat ($urandom_range(1, 3)) frame.push_back(8'($urandom_range(0, 255)));
                    end
                    armed_frame(8'hC3);
                end
                4: armed_frame($urandom_range(0, 1) ? 8'h4B : 8'hD2);
                5: begin
                    send_token(8'h2D, dev_addr, 4'd0);
                    a = $urandom_range(1, 9);
                    for (int i = 0; i < a; i++) begin
                        data_in = frame[i]; data_in_strb = 1'b1; tick(); data_in_strb = 1'b0;
                    end
                    data_in_fail = 1'b1; tick(); data_in_fail = 1'b0;
                    push(1'b1, 2'd3, cyc);
                    wait_drain(10);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: send_token(8'h2D, dev_addr ^ 7'(1 << $urandom_range(0, 6)), 4'd0);
                        1: send_token(8'h2D, dev_addr, 4'($urandom_range(1, 15)));
                        default: send_token(8'hE1, dev_addr, 4'd0);
                    endcase
                    check("busy_ignored_token", {63'd0, busy}, 64'd0);
                    send_frame(8'hC3, e);
                    wait_drain(5);
                end
            endcase
        end

        check("queue_empty_at_end", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
